// File: rtl/rect_track_ctrl.sv
// Frame-rate rectangle tracker: qualifies per-frame detector boxes, runs a
// SEARCH/ACQUIRE/TRACK/LOST state machine and smooths the tracked box.
module rect_track_ctrl #(
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned IMG_H       = 480,
    parameter int unsigned MIN_SIZE    = 8,
    parameter int unsigned ACQ_FRAMES  = 3,
    parameter int unsigned LOST_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_per_frame_vsync,
    input  logic       i_rect_flag,
    input  logic [9:0] i_rect_up,
    input  logic [9:0] i_rect_down,
    input  logic [9:0] i_rect_left,
    input  logic [9:0] i_rect_right,
    output logic [1:0] o_trk_state,
    output logic       o_trk_valid,
    output logic [9:0] o_box_up,
    output logic [9:0] o_box_down,
    output logic [9:0] o_box_left,
    output logic [9:0] o_box_right,
    output logic [9:0] o_trk_cx,
    output logic [9:0] o_trk_cy,
    output logic       o_frame_done
);

    localparam int unsigned CNT_MAX = (ACQ_FRAMES > LOST_FRAMES) ? ACQ_FRAMES : LOST_FRAMES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [10:0]   IMG_W_L    = 11'(IMG_W);
    localparam logic [10:0]   IMG_H_L    = 11'(IMG_H);
    localparam logic [10:0]   MIN_L      = 11'(MIN_SIZE);
    // Count value at which one more hit/miss reaches the threshold
    localparam logic [CW-1:0] ACQ_LAST   = CW'(ACQ_FRAMES - 1);
    localparam logic [CW-1:0] LOST_LAST  = CW'(LOST_FRAMES - 1);

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLost    = 2'd3
    } state_t;

    function automatic logic [9:0] avg10(input logic [9:0] a, input logic [9:0] b);
        return 10'(({1'b0, a} + {1'b0, b}) >> 1);
    endfunction

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_hit_cnt, w_hit_cnt_nxt;
    logic [CW-1:0] r_miss_cnt, w_miss_cnt_nxt;
    logic [9:0]    r_box_up, r_box_down, r_box_left, r_box_right;
    logic [9:0]    w_box_up_nxt, w_box_down_nxt, w_box_left_nxt, w_box_right_nxt;
    logic [9:0]    r_cx, r_cy;
    logic          r_vsync_d;
    logic          r_pipe_e1;
    logic          r_frame_done;

    logic          w_vsync_fall;
    logic          w_hit;
    logic [9:0]    w_width, w_height;
    logic [CW-1:0] w_hit_inc, w_miss_inc;

    assign w_vsync_fall = r_vsync_d & ~i_per_frame_vsync;

    assign w_width  = i_rect_right - i_rect_left;
    assign w_height = i_rect_down - i_rect_up;
    assign w_hit    = i_rect_flag
                    && (i_rect_right > i_rect_left)
                    && (i_rect_down > i_rect_up)
                    && ({1'b0, w_width} >= MIN_L)
                    && ({1'b0, w_height} >= MIN_L)
                    && ({1'b0, i_rect_right} < IMG_W_L)
                    && ({1'b0, i_rect_down} < IMG_H_L);

    assign w_hit_inc  = (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + CW'(1);
    assign w_miss_inc = (r_miss_cnt == '1) ? r_miss_cnt : r_miss_cnt + CW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_hit_cnt_nxt   = r_hit_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_box_up_nxt    = r_box_up;
        w_box_down_nxt  = r_box_down;
        w_box_left_nxt  = r_box_left;
        w_box_right_nxt = r_box_right;
        if (w_vsync_fall) begin
            unique case (r_state)
                // SEARCH and ACQUIRE share the threshold check since hit_cnt is 0 in SEARCH
                StSearch, StAcquire: begin
                    if (!w_hit) begin
                        w_state_nxt   = StSearch;
                        w_hit_cnt_nxt = '0;
                    end else if (r_hit_cnt == ACQ_LAST) begin
                        w_state_nxt     = StTrack;
                        w_hit_cnt_nxt   = '0;
                        w_miss_cnt_nxt  = '0;
                        w_box_up_nxt    = i_rect_up;
                        w_box_down_nxt  = i_rect_down;
                        w_box_left_nxt  = i_rect_left;
                        w_box_right_nxt = i_rect_right;
                    end else begin
                        w_state_nxt   = StAcquire;
                        w_hit_cnt_nxt = w_hit_inc;
                    end
                end
                StTrack, StLost: begin
                    if (w_hit) begin
                        w_state_nxt     = StTrack;
                        w_miss_cnt_nxt  = '0;
                        w_box_up_nxt    = avg10(r_box_up, i_rect_up);
                        w_box_down_nxt  = avg10(r_box_down, i_rect_down);
                        w_box_left_nxt  = avg10(r_box_left, i_rect_left);
                        w_box_right_nxt = avg10(r_box_right, i_rect_right);
                    end else if (r_miss_cnt == LOST_LAST) begin
                        w_state_nxt    = StSearch;
                        w_hit_cnt_nxt  = '0;
                        w_miss_cnt_nxt = '0;
                    end else begin
                        w_state_nxt    = StLost;
                        w_miss_cnt_nxt = w_miss_inc;
                    end
                end
                default: w_state_nxt = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StSearch;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_box_up    <= '0;
            r_box_down  <= '0;
            r_box_left  <= '0;
            r_box_right <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_cnt   <= w_hit_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_box_up    <= w_box_up_nxt;
            r_box_down  <= w_box_down_nxt;
            r_box_left  <= w_box_left_nxt;
            r_box_right <= w_box_right_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d    <= 1'b0;
            r_pipe_e1    <= 1'b0;
            r_frame_done <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
        end else begin
            r_vsync_d    <= i_per_frame_vsync;
            r_pipe_e1    <= w_vsync_fall;
            r_frame_done <= r_pipe_e1;
            if (r_pipe_e1) begin
                r_cx <= avg10(r_box_left, r_box_right);
                r_cy <= avg10(r_box_up, r_box_down);
            end
        end
    end

    assign o_trk_state  = r_state;
    assign o_trk_valid  = (r_state == StTrack) || (r_state == StLost);
    assign o_box_up     = r_box_up;
    assign o_box_down   = r_box_down;
    assign o_box_left   = r_box_left;
    assign o_box_right  = r_box_right;
    assign o_trk_cx     = r_cx;
    assign o_trk_cy     = r_cy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_rect_track_ctrl.sv
// Scoreboard bench for rect_track_ctrl: a behavioural model predicts each
// frame's outputs, which are compared when frame_done pulses.
module tb_rect_track_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_per_frame_vsync;
    logic       i_rect_flag;
    logic [9:0] i_rect_up, i_rect_down, i_rect_left, i_rect_right;
    logic [1:0] o_trk_state;
    logic       o_trk_valid;
    logic [9:0] o_box_up, o_box_down, o_box_left, o_box_right;
    logic [9:0] o_trk_cx, o_trk_cy;
    logic       o_frame_done;

    rect_track_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_per_frame_vsync (i_per_frame_vsync),
        .i_rect_flag       (i_rect_flag),
        .i_rect_up         (i_rect_up),
        .i_rect_down       (i_rect_down),
        .i_rect_left       (i_rect_left),
        .i_rect_right      (i_rect_right),
        .o_trk_state       (o_trk_state),
        .o_trk_valid       (o_trk_valid),
        .o_box_up          (o_box_up),
        .o_box_down        (o_box_down),
        .o_box_left        (o_box_left),
        .o_box_right       (o_box_right),
        .o_trk_cx          (o_trk_cx),
        .o_trk_cy          (o_trk_cy),
        .o_frame_done      (o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int vl;
        int up;
        int dn;
        int lf;
        int rt;
        int cx;
        int cy;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state
    int m_state, m_hit, m_miss;
    int m_up, m_dn, m_lf, m_rt;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hit = 0; m_miss = 0;
        m_up = 0; m_dn = 0; m_lf = 0; m_rt = 0;
    endtask

    function automatic bit is_hit(input bit f, input int u, input int d, input int l, input int r);
        return f && (r > l) && (d > u) && (r - l >= 8) && (d - u >= 8) && (r < 640) && (d < 480);
    endfunction

    task automatic model_step(input bit f, input int u, input int d, input int l, input int r);
        bit h;
        h = is_hit(f, u, d, l, r);
        case (m_state)
            0, 1: begin
                if (!h) begin
                    m_state = 0; m_hit = 0;
                end else if (m_hit + 1 == 3) begin
                    m_state = 2; m_hit = 0; m_miss = 0;
                    m_up = u; m_dn = d; m_lf = l; m_rt = r;
                end else begin
                    m_state = 1; m_hit = m_hit + 1;
                end
            end
            default: begin
                if (h) begin
                    m_state = 2; m_miss = 0;
                    m_up = (m_up + u) / 2; m_dn = (m_dn + d) / 2;
                    m_lf = (m_lf + l) / 2; m_rt = (m_rt + r) / 2;
                end else if (m_miss + 1 == 5) begin
                    m_state = 0; m_hit = 0; m_miss = 0;
                end else begin
                    m_state = 3; m_miss = m_miss + 1;
                end
            end
        endcase
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.st = m_state;
        e.vl = (m_state >= 2) ? 1 : 0;
        e.up = m_up; e.dn = m_dn; e.lf = m_lf; e.rt = m_rt;
        e.cx = (m_lf + m_rt) / 2;
        e.cy = (m_up + m_dn) / 2;
        return e;
    endfunction

    // Scoreboard: every frame_done pops one prediction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_frame_done) begin
            if (q_exp.size() == 0) begin
                check_eq("fd_unexpected", 1, 0);
            end else begin
                e = q_exp.pop_front();
                check_eq("state", int'(o_trk_state), e.st);
                check_eq("valid", int'(o_trk_valid), e.vl);
                check_eq("box_up", int'(o_box_up), e.up);
                check_eq("box_down", int'(o_box_down), e.dn);
                check_eq("box_left", int'(o_box_left), e.lf);
                check_eq("box_right", int'(o_box_right), e.rt);
                check_eq("cx", int'(o_trk_cx), e.cx);
                check_eq("cy", int'(o_trk_cy), e.cy);
            end
        end
    end

    task automatic run_frame(input bit f, input int u, input int d, input int l, input int r);
        @(negedge clk);
        i_per_frame_vsync = 1'b0;
        i_rect_flag  = f;
        i_rect_up    = 10'(u);
        i_rect_down  = 10'(d);
        i_rect_left  = 10'(l);
        i_rect_right = 10'(r);
        model_step(f, u, d, l, r);
        q_exp.push_back(model_exp());
        @(posedge clk);
        @(negedge clk);
        check_eq("fd_e1", int'(o_frame_done), 0);
        check_eq("state_e1", int'(o_trk_state), m_state);
        @(negedge clk);
        check_eq("fd_e2", int'(o_frame_done), 1);
        @(negedge clk);
        check_eq("fd_e3", int'(o_frame_done), 0);
        // Garbage between frames must be ignored
        i_rect_flag  = 1'($urandom);
        i_rect_up    = 10'($urandom);
        i_rect_down  = 10'($urandom);
        i_rect_left  = 10'($urandom);
        i_rect_right = 10'($urandom);
        i_per_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, int'(o_trk_state), 0);
        check_eq({tag, "_valid"}, int'(o_trk_valid), 0);
        check_eq({tag, "_box"}, int'(o_box_up | o_box_down | o_box_left | o_box_right), 0);
        check_eq({tag, "_cxy"}, int'(o_trk_cx | o_trk_cy), 0);
        check_eq({tag, "_fd"}, int'(o_frame_done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_per_frame_vsync = 1'b1;
        i_rect_flag = 1'b0;
        i_rect_up = '0; i_rect_down = '0; i_rect_left = '0; i_rect_right = '0;
        model_reset();
        #2;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Acquire and lock
        for (int i = 0; i < 3; i++) run_frame(1'b1, 100, 200, 150, 260);
        check_eq("lock_state", int'(o_trk_state), 2);
        // Smoothing in TRACK
        run_frame(1'b1, 110, 210, 160, 270);
        // 4 misses then a hit
        for (int i = 0; i < 4; i++) run_frame(1'b0, 110, 210, 160, 270);
        run_frame(1'b1, 110, 210, 160, 270);
        // 5 misses release the target
        for (int i = 0; i < 5; i++) run_frame(1'b0, 0, 0, 0, 0);
        check_eq("released_valid", int'(o_trk_valid), 0);

        // Degenerate boxes each drop ACQUIRE back to SEARCH
        run_frame(1'b1, 100, 200, 150, 260);
        run_frame(1'b1, 100, 200, 100, 105);
        run_frame(1'b1, 100, 200, 150, 260);
        run_frame(1'b1, 100, 200, 600, 640);
        run_frame(1'b1, 100, 200, 150, 260);
        run_frame(1'b1, 100, 200, 260, 150);
        check_eq("degen_state", int'(o_trk_state), 0);

        // Async reset during ACQUIRE with vsync held high
        run_frame(1'b1, 100, 200, 150, 260);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rstA");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        run_frame(1'b1, 100, 200, 150, 260);
        check_eq("post_rst_state", int'(o_trk_state), 1);

        // Reset in flight between E+1 and E+2 discards the frame
        @(negedge clk);
        i_per_frame_vsync = 1'b0;
        i_rect_flag = 1'b1;
        i_rect_up = 10'd100; i_rect_down = 10'd200; i_rect_left = 10'd150; i_rect_right = 10'd260;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rstB");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check_eq("rstB_no_fd", int'(o_frame_done), 0);
        i_per_frame_vsync = 1'b1;
        repeat (3) @(negedge clk);

        // Boundary box: exactly MIN_SIZE, right/down at the image edge
        for (int i = 0; i < 3; i++) run_frame(1'b1, 471, 479, 631, 639);
        check_eq("edge_lock", int'(o_trk_state), 2);

        // Random frames
        for (int i = 0; i < 40; i++) begin
            int u, l;
            u = $urandom_range(0, 470);
            l = $urandom_range(0, 630);
            run_frame($urandom_range(0, 3) != 0, u, u + $urandom_range(0, 20),
                      l, l + $urandom_range(0, 20));
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
